// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared adder with a single-entry, no-bubble output register.
// Optional signed-overflow flag output o_ovf is enabled by defining ADDER_ARBITER_OVF_EN.
module adder_arbiter #(
  parameter int unsigned NB_ADDER = 32,
  parameter int unsigned N_REQ    = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_REQ-1:0]             i_req_valid,
  output logic [N_REQ-1:0]             o_req_ready,
  input  logic [N_REQ*NB_ADDER-1:0]    i_req_a,
  input  logic [N_REQ*NB_ADDER-1:0]    i_req_b,
  output logic [NB_ADDER-1:0]          o_sum,
  output logic [$clog2(N_REQ)-1:0]     o_sum_id,
  output logic                         o_sum_valid,
  input  logic                         i_sum_ready
`ifdef ADDER_ARBITER_OVF_EN
  ,
  output logic                         o_ovf
`endif
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q;
  logic                can_accept_c;
  logic [N_REQ-1:0]    grant_c;
  logic [ID_W-1:0]     grant_id_c;
  logic                xfer_c;
  int unsigned         idx;
  logic [NB_ADDER-1:0] opa_c, opb_c, sum_c;

  // A new operand pair can enter when the register is empty or drains this cycle.
  assign can_accept_c = i_rst_n && ((state_q == EMPTY) || i_sum_ready);

  // Round-robin search starting at rr_ptr_q, wrapping to 0.
  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    xfer_c     = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!xfer_c && can_accept_c && i_req_valid[ID_W'(idx)]) begin
        grant_c[ID_W'(idx)] = 1'b1;
        grant_id_c          = ID_W'(idx);
        xfer_c              = 1'b1;
      end
    end
  end

  assign o_req_ready = grant_c;

  // Operand mux ahead of the single shared adder.
  always_comb begin
    opa_c = '0;
    opb_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant_c[k]) begin
        opa_c = i_req_a[k*NB_ADDER +: NB_ADDER];
        opb_c = i_req_b[k*NB_ADDER +: NB_ADDER];
      end
    end
  end

  assign sum_c = opa_c + opb_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer_c) state_d = FULL;
      FULL:    if (i_sum_ready && !xfer_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign o_sum_valid = (state_q == FULL);

  // Result payload and round-robin pointer load only on a transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
      o_sum    <= '0;
      o_sum_id <= '0;
    end else if (xfer_c) begin
      rr_ptr_q <= (grant_id_c == ID_W'(N_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
      o_sum    <= sum_c;
      o_sum_id <= grant_id_c;
    end
  end

`ifdef ADDER_ARBITER_OVF_EN
  // Signed overflow: operands agree in sign, sum does not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_ovf <= 1'b0;
    else if (xfer_c) o_ovf <= (opa_c[NB_ADDER-1] == opb_c[NB_ADDER-1]) &&
                              (sum_c[NB_ADDER-1] != opa_c[NB_ADDER-1]);
  end
`endif

endmodule
